// File: rtl/rf_access_ctrl.sv
// Operand-fetch / write-back sequencer in front of the register file.
// Runs four-phase level handshakes (re/rack, we/wack), gives write-back
// priority over operand fetch, and flags a sticky error when an ack phase
// stalls for ACK_TIMEOUT cycles.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready for a write-back or an operand fetch
// WR_REQ | rf_we high, waiting for rf_wack to rise
// WR_REL | rf_we low, waiting for rf_wack to fall
// RS_REQ | rf_re high on rs, waiting for rf_rack to rise (captures op_rs)
// RS_REL | rf_re low, waiting for rf_rack to fall
// RT_REQ | rf_re high on rt, waiting for rf_rack to rise (captures op_rt)
// RT_REL | rf_re low, waiting for rf_rack to fall
// HOLD   | operands presented on op_valid until the consumer takes them
module rf_access_ctrl #(
  parameter int REG_SZ      = 32,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [4:0]        rs_idx,
  input  logic [4:0]        rt_idx,
  input  logic              need_rs,
  input  logic              need_rt,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [REG_SZ-1:0] op_rs,
  output logic [REG_SZ-1:0] op_rt,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [4:0]        wb_idx,
  input  logic [REG_SZ-1:0] wb_data,
  output logic [4:0]        rf_r_idx,
  output logic              rf_re,
  input  logic              rf_rack,
  input  logic [REG_SZ-1:0] rf_dout,
  output logic [4:0]        rf_w_idx,
  output logic              rf_we,
  input  logic              rf_wack,
  output logic [REG_SZ-1:0] rf_din,
  output logic              err
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_REL, RS_REQ, RS_REL, RT_REQ, RT_REL, HOLD
  } state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   tmo_cnt;
  logic               waiting;
  logic               timeout;
  logic               need_rt_q;
  logic [4:0]         rs_q, rt_q;
  logic [4:0]         w_idx_q;
  logic [REG_SZ-1:0]  w_data_q;

  assign rf_w_idx = w_idx_q;
  assign rf_din   = w_data_q;
  assign rf_r_idx = (state == RT_REQ || state == RT_REL) ? rt_q : rs_q;

  // Next-state and handshake outputs; a stalled phase falls back to IDLE.
  always_comb begin
    state_nx    = state;
    issue_ready = 1'b0;
    wb_ready    = 1'b0;
    rf_re       = 1'b0;
    rf_we       = 1'b0;
    op_valid    = 1'b0;
    waiting     = 1'b0;
    case (state)
      IDLE: begin
        wb_ready    = 1'b1;
        issue_ready = !wb_valid;
        if (wb_valid) begin
          // r0 is hardwired zero in the regfile, so its write is simply dropped
          if (wb_idx != 5'd0) state_nx = WR_REQ;
        end else if (issue_valid) begin
          state_nx = need_rs ? RS_REQ : (need_rt ? RT_REQ : HOLD);
        end
      end
      WR_REQ: begin
        rf_we   = 1'b1;
        waiting = 1'b1;
        if (rf_wack) state_nx = WR_REL;
      end
      WR_REL: begin
        waiting = 1'b1;
        if (!rf_wack) state_nx = IDLE;
      end
      RS_REQ: begin
        rf_re   = 1'b1;
        waiting = 1'b1;
        if (rf_rack) state_nx = RS_REL;
      end
      RS_REL: begin
        waiting = 1'b1;
        if (!rf_rack) state_nx = need_rt_q ? RT_REQ : HOLD;
      end
      RT_REQ: begin
        rf_re   = 1'b1;
        waiting = 1'b1;
        if (rf_rack) state_nx = RT_REL;
      end
      RT_REL: begin
        waiting = 1'b1;
        if (!rf_rack) state_nx = HOLD;
      end
      HOLD: begin
        op_valid = 1'b1;
        if (op_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    timeout = waiting && (state_nx == state) && (tmo_cnt == TMO_LAST);
    if (timeout) state_nx = IDLE;
  end

  // State register, per-phase timeout counter and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tmo_cnt <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_nx;
      if (state_nx != state) tmo_cnt <= '0;
      else if (waiting)      tmo_cnt <= tmo_cnt + 1'b1;
      if (timeout) err <= 1'b1;
    end
  end

  // Request capture at accept; write-back index/data held until the next write.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_idx_q   <= '0;
      w_data_q  <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      need_rt_q <= 1'b0;
    end else if (state == IDLE) begin
      if (wb_valid) begin
        w_idx_q  <= wb_idx;
        w_data_q <= wb_data;
      end else if (issue_valid) begin
        rs_q      <= rs_idx;
        rt_q      <= rt_idx;
        need_rt_q <= need_rt;
      end
    end
  end

  // Operand registers: zeroed on accept so unfetched operands read as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_rs <= '0;
      op_rt <= '0;
    end else begin
      if (state == IDLE && !wb_valid && issue_valid) begin
        op_rs <= '0;
        op_rt <= '0;
      end
      if (state == RS_REQ && rf_rack) op_rs <= rf_dout;
      if (state == RT_REQ && rf_rack) op_rt <= rf_dout;
    end
  end

endmodule
